// File: rtl/multicycle_alu.sv
// ---------------------------------------------------------------------------
// multicycle_alu : ALU with single-cycle ADD/SUB/AND/OR and iterative unsigned
//                  MUL/DIV/MOD behind a start/busy/done handshake.
// Revision       : 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module multicycle_alu #(
   parameter int N  = 32,
   parameter int CW = $clog2(N) + 1
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         start_i,
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   input  logic [2:0]   opcode_i,
   output logic         busy_o,
   output logic         done_o,
   output logic [N-1:0] result_o,
   output logic [3:0]   flags_o
);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_MUL = 3'b100;
   localparam logic [2:0] OP_DIV = 3'b101;
   localparam logic [2:0] OP_MOD = 3'b110;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t         state_q, state_d;
   logic [N-1:0]   a_q, a_d;
   logic [N-1:0]   b_q, b_d;
   logic [2:0]     op_q, op_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [N-1:0]   hi_q, hi_d;
   logic [N-1:0]   rem_q, rem_d;
   logic [N-1:0]   result_q, result_d;
   logic [3:0]     flags_q, flags_d;

   logic [N:0]     add_full;
   logic [N-1:0]   sub_res;
   logic [N-1:0]   alu_res;
   logic           alu_c;
   logic           alu_v;

   always_comb begin
      add_full = {1'b0, a_i} + {1'b0, b_i};
      sub_res  = a_i - b_i;
      alu_res  = '0;
      alu_c    = 1'b0;
      alu_v    = 1'b0;
      case (opcode_i)
         OP_ADD: begin
            alu_res = add_full[N-1:0];
            alu_c   = add_full[N];
            alu_v   = (a_i[N-1] == b_i[N-1]) && (add_full[N-1] != a_i[N-1]);
         end
         OP_SUB: begin
            alu_res = sub_res;
            alu_c   = (a_i >= b_i);
            alu_v   = (a_i[N-1] != b_i[N-1]) && (sub_res[N-1] != a_i[N-1]);
         end
         OP_AND:  alu_res = a_i & b_i;
         OP_OR:   alu_res = a_i | b_i;
         default: alu_res = '0;
      endcase
   end

   // Multiplier: {hi_q, b_q} is the 2N-bit accumulator; product bits shift
   // into the top of b_q as multiplier bits leave from its bottom.
   logic [N:0]     mul_sum;
   logic [N-1:0]   mul_lo;

   assign mul_sum = {1'b0, hi_q} + {1'b0, (b_q[0] ? a_q : {N{1'b0}})};
   assign mul_lo  = {mul_sum[0], b_q[N-1:1]};

   // Restoring divider: a_q shifts the dividend out MSB-first while quotient
   // bits shift in at its LSB.
   logic [N:0]     rem_sh;
   logic [N-1:0]   rem_sub;
   logic           q_bit;
   logic [N-1:0]   rem_nxt;
   logic [N-1:0]   quo_nxt;
   logic [N-1:0]   div_res;

   assign rem_sh  = {rem_q, a_q[N-1]};
   assign rem_sub = rem_sh[N-1:0] - b_q;
   assign q_bit   = (rem_sh >= {1'b0, b_q});
   assign rem_nxt = q_bit ? rem_sub : rem_sh[N-1:0];
   assign quo_nxt = {a_q[N-2:0], q_bit};
   assign div_res = (op_q == OP_MOD) ? rem_nxt : quo_nxt;

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      rem_d    = rem_q;
      result_d = result_q;
      flags_d  = flags_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               a_d   = a_i;
               b_d   = b_i;
               op_d  = opcode_i;
               hi_d  = '0;
               rem_d = '0;
               cnt_d = CW'(N);
               case (opcode_i)
                  OP_MUL:         state_d = S_MUL;
                  OP_DIV, OP_MOD: state_d = S_DIV;
                  default: begin
                     state_d  = S_DONE;
                     result_d = alu_res;
                     flags_d  = {alu_res[N-1], (alu_res == '0), alu_c, alu_v};
                  end
               endcase
            end else begin
               state_d = S_IDLE;
            end
         end
         S_MUL: begin
            hi_d  = mul_sum[N:1];
            b_d   = mul_lo;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d  = S_DONE;
               result_d = mul_lo;
               flags_d  = {mul_lo[N-1], (mul_lo == '0), 1'b0, |mul_sum[N:1]};
            end
         end
         S_DIV: begin
            rem_d = rem_nxt;
            a_d   = quo_nxt;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d  = S_DONE;
               result_d = div_res;
               flags_d  = {div_res[N-1], (div_res == '0), 1'b0, (b_q == '0)};
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         cnt_q    <= '0;
         hi_q     <= '0;
         rem_q    <= '0;
         result_q <= '0;
         flags_q  <= '0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         rem_q    <= rem_d;
         result_q <= result_d;
         flags_q  <= flags_d;
      end
   end

   assign busy_o   = (state_q == S_MUL) || (state_q == S_DIV);
   assign done_o   = (state_q == S_DONE);
   assign result_o = result_q;
   assign flags_o  = flags_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_alu.sv
// ---------------------------------------------------------------------------
// tb_multicycle_alu : randomized self-checking bench for multicycle_alu (N=8).
// Revision          : 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_multicycle_alu;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [N-1:0] a, b;
   logic [2:0]   opc;
   logic         busy, done;
   logic [N-1:0] result;
   logic [3:0]   flags;

   int checks = 0;
   int errors = 0;

   multicycle_alu #(.N(N)) dut (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .start_i  (start),
      .a_i      (a),
      .b_i      (b),
      .opcode_i (opc),
      .busy_o   (busy),
      .done_o   (done),
      .result_o (result),
      .flags_o  (flags)
   );

   always #5 clk = ~clk;

   // Reference: plain integer arithmetic on the operation's definition.
   function automatic void model(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y,
                                 output logic [7:0] r, output logic [3:0] f);
      int ux, uy, sx, sy, t;
      logic c, v;
      ux = int'(x); uy = int'(y);
      sx = int'($signed(x)); sy = int'($signed(y));
      c = 1'b0; v = 1'b0; r = 8'h00; t = 0;
      case (op)
         3'd0: begin t = ux + uy; r = t[7:0]; c = (t > 255); v = (sx + sy > 127) || (sx + sy < -128); end
         3'd1: begin t = ux - uy; r = t[7:0]; c = (ux >= uy); v = (sx - sy > 127) || (sx - sy < -128); end
         3'd2: r = x & y;
         3'd3: r = x | y;
         3'd4: begin t = ux * uy; r = t[7:0]; v = (t > 255); end
         3'd5: begin if (uy == 0) begin r = 8'hFF; v = 1'b1; end else begin t = ux / uy; r = t[7:0]; end end
         3'd6: begin if (uy == 0) begin r = x; v = 1'b1; end else begin t = ux % uy; r = t[7:0]; end end
         default: r = 8'h00;
      endcase
      f = {r[7], (r == 8'h00), c, v};
   endfunction

   // Issues one request and waits (bounded) for done; lat=-1 on timeout.
   task automatic do_op(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y,
                        output logic [7:0] r, output logic [3:0] f, output int lat, output int bcnt);
      @(negedge clk);
      start = 1'b1; opc = op; a = x; b = y;
      @(negedge clk);
      start = 1'b0;
      lat = 1; bcnt = 0;
      while (!done && lat < 40) begin
         if (busy) bcnt++;
         @(negedge clk);
         lat++;
      end
      if (!done) lat = -1;
      r = result; f = flags;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; opc = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, done} !== 2'b00) begin errors++; $display("FAIL reset_busy_done got %b want 00", {busy, done}); end
      checks++;
      if (result !== 8'h00) begin errors++; $display("FAIL reset_result got %h want 00", result); end
      checks++;
      if (flags !== 4'h0) begin errors++; $display("FAIL reset_flags got %b want 0000", flags); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_add_sub();
      logic [7:0] r, er; logic [3:0] f, ef; int lat, bc;
      do_op(3'd0, 8'h7F, 8'h01, r, f, lat, bc);
      checks++;
      if ({r, f} !== {8'h80, 4'b1001} || lat != 1 || bc != 0) begin
         errors++; $display("FAIL add_7f_01 got r=%h f=%b lat=%0d busy=%0d want r=80 f=1001 lat=1 busy=0", r, f, lat, bc);
      end
      do_op(3'd1, 8'h05, 8'h05, r, f, lat, bc);
      checks++;
      if ({r, f} !== {8'h00, 4'b0110} || lat != 1) begin
         errors++; $display("FAIL sub_05_05 got r=%h f=%b lat=%0d want r=00 f=0110 lat=1", r, f, lat);
      end
      do_op(3'd1, 8'h03, 8'h05, r, f, lat, bc);
      checks++;
      if ({r, f} !== {8'hFE, 4'b1000} || lat != 1) begin
         errors++; $display("FAIL sub_03_05 got r=%h f=%b lat=%0d want r=fe f=1000 lat=1", r, f, lat);
      end
      for (int i = 0; i < 24; i++) begin
         logic [2:0] op; logic [7:0] x, y;
         op = 3'($urandom_range(0, 1)); x = 8'($urandom); y = 8'($urandom);
         model(op, x, y, er, ef);
         do_op(op, x, y, r, f, lat, bc);
         checks++;
         if ({r, f} !== {er, ef} || lat != 1 || bc != 0) begin
            errors++; $display("FAIL addsub_rand op=%0d a=%h b=%h got r=%h f=%b lat=%0d want r=%h f=%b lat=1", op, x, y, r, f, lat, er, ef);
         end
      end
   endtask

   task automatic test_logic();
      logic [7:0] r, er; logic [3:0] f, ef; int lat, bc;
      for (int i = 0; i < 15; i++) begin
         logic [2:0] op; logic [7:0] x, y;
         op = (i % 3 == 2) ? 3'd7 : 3'(2 + (i % 3)); x = 8'($urandom); y = 8'($urandom);
         model(op, x, y, er, ef);
         do_op(op, x, y, r, f, lat, bc);
         checks++;
         if ({r, f} !== {er, ef} || lat != 1) begin
            errors++; $display("FAIL logic_rand op=%0d a=%h b=%h got r=%h f=%b lat=%0d want r=%h f=%b lat=1", op, x, y, r, f, lat, er, ef);
         end
      end
   endtask

   task automatic test_mul();
      logic [7:0] r, er; logic [3:0] f, ef; int lat, bc;
      do_op(3'd4, 8'h10, 8'h11, r, f, lat, bc);
      checks++;
      if ({r, f} !== {8'h10, 4'b0001} || lat != 9 || bc != 8) begin
         errors++; $display("FAIL mul_10_11 got r=%h f=%b lat=%0d busy=%0d want r=10 f=0001 lat=9 busy=8", r, f, lat, bc);
      end
      do_op(3'd4, 8'h0C, 8'h0B, r, f, lat, bc);
      checks++;
      if ({r, f} !== {8'h84, 4'b1000} || lat != 9) begin
         errors++; $display("FAIL mul_0c_0b got r=%h f=%b lat=%0d want r=84 f=1000 lat=9", r, f, lat);
      end
      for (int i = 0; i < 12; i++) begin
         logic [7:0] x, y;
         x = 8'($urandom); y = (i < 2) ? 8'(i * 255) : 8'($urandom);
         model(3'd4, x, y, er, ef);
         do_op(3'd4, x, y, r, f, lat, bc);
         checks++;
         if ({r, f} !== {er, ef} || lat != 9 || bc != 8) begin
            errors++; $display("FAIL mul_rand a=%h b=%h got r=%h f=%b lat=%0d busy=%0d want r=%h f=%b lat=9 busy=8", x, y, r, f, lat, bc, er, ef);
         end
      end
   endtask

   task automatic test_div();
      logic [7:0] r, er; logic [3:0] f, ef; int lat, bc;
      logic [2:0] dop [4]; logic [7:0] da [4]; logic [7:0] db [4]; logic [7:0] dr [4]; logic [3:0] df [4];
      dop = '{3'd5, 3'd6, 3'd6, 3'd5};
      da  = '{8'd200, 8'd200, 8'd9, 8'd9};
      db  = '{8'd7, 8'd7, 8'd0, 8'd0};
      dr  = '{8'd28, 8'd4, 8'd9, 8'hFF};
      df  = '{4'b0000, 4'b0000, 4'b0001, 4'b1001};
      for (int i = 0; i < 4; i++) begin
         do_op(dop[i], da[i], db[i], r, f, lat, bc);
         checks++;
         if ({r, f} !== {dr[i], df[i]} || lat != 9 || bc != 8) begin
            errors++; $display("FAIL div_directed op=%0d a=%0d b=%0d got r=%h f=%b lat=%0d want r=%h f=%b lat=9", dop[i], da[i], db[i], r, f, lat, dr[i], df[i]);
         end
      end
      for (int i = 0; i < 16; i++) begin
         logic [2:0] op; logic [7:0] x, y;
         op = 3'($urandom_range(5, 6)); x = 8'($urandom);
         y = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255) >> $urandom_range(0, 6));
         model(op, x, y, er, ef);
         do_op(op, x, y, r, f, lat, bc);
         checks++;
         if ({r, f} !== {er, ef} || lat != 9) begin
            errors++; $display("FAIL div_rand op=%0d a=%h b=%h got r=%h f=%b lat=%0d want r=%h f=%b lat=9", op, x, y, r, f, lat, er, ef);
         end
      end
   endtask

   task automatic test_ignore_busy();
      logic [7:0] er; logic [3:0] ef; int lat;
      @(negedge clk);
      start = 1'b1; opc = 3'd4; a = 8'h0C; b = 8'h0B;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      start = 1'b1; opc = 3'd2; a = 8'hFF; b = 8'h0F;
      @(negedge clk); start = 1'b0;
      lat = 4;
      while (!done && lat < 40) begin @(negedge clk); lat++; end
      checks++;
      if ({result, flags} !== {8'h84, 4'b1000} || lat != 9) begin
         errors++; $display("FAIL ignore_while_busy got r=%h f=%b lat=%0d want r=84 f=1000 lat=9", result, flags, lat);
      end
      // AND issued in the DONE cycle must be accepted at once.
      start = 1'b1; opc = 3'd2; a = 8'h3C; b = 8'h0F;
      model(3'd2, 8'h3C, 8'h0F, er, ef);
      @(negedge clk); start = 1'b0;
      checks++;
      if (done !== 1'b1 || {result, flags} !== {er, ef}) begin
         errors++; $display("FAIL accept_in_done got done=%b r=%h f=%b want done=1 r=%h f=%b", done, result, flags, er, ef);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL done_single_pulse got %b want 0", done); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] er [6]; logic [3:0] ef [6];
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         logic [2:0] op; logic [7:0] x, y;
         op = (i == 5) ? 3'd0 : 3'($urandom_range(0, 3));
         x = (i == 5) ? 8'h01 : 8'($urandom);
         y = (i == 5) ? 8'h01 : 8'($urandom);
         model(op, x, y, er[i], ef[i]);
         start = 1'b1; opc = op; a = x; b = y;
         @(negedge clk);
         checks++;
         if (done !== 1'b1 || {result, flags} !== {er[i], ef[i]}) begin
            errors++; $display("FAIL back_to_back idx=%0d got done=%b r=%h f=%b want done=1 r=%h f=%b", i, done, result, flags, er[i], ef[i]);
         end
      end
      start = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_op();
      logic [7:0] r; logic [3:0] f; int lat, bc, ndone;
      @(negedge clk);
      start = 1'b1; opc = 3'd5; a = 8'd200; b = 8'd7;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL div_busy_before_reset got %b want 1", busy); end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, result, flags} !== 14'd0) begin
         errors++; $display("FAIL async_reset got busy=%b done=%b r=%h f=%b want all 0", busy, done, result, flags);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (done || busy) ndone++;
      end
      checks++;
      if (ndone != 0) begin errors++; $display("FAIL no_done_after_abort got %0d active cycles want 0", ndone); end
      do_op(3'd0, 8'h22, 8'h11, r, f, lat, bc);
      checks++;
      if ({r, f} !== {8'h33, 4'b0000} || lat != 1) begin
         errors++; $display("FAIL add_after_reset got r=%h f=%b lat=%0d want r=33 f=0000 lat=1", r, f, lat);
      end
   endtask

   initial begin
      test_reset();
      test_add_sub();
      test_logic();
      test_mul();
      test_div();
      test_ignore_busy();
      test_back_to_back();
      test_reset_mid_op();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog_timeout simulation did not finish");
      $fatal(1);
   end

endmodule

`default_nettype wire
